// File: rtl/fpu_add_pkg.sv
// Shared FP-adder definitions: exponent/shift defaults for double and single
// precision, and the packed result record of the exponent-align stage.
package fpu_add_pkg;

  localparam int DP_EW        = 11;
  localparam int DP_MAX_SHIFT = 55;
  localparam int DP_SW        = $clog2(DP_MAX_SHIFT + 1);
  localparam int SP_EW        = 8;
  localparam int SP_MAX_SHIFT = 26;

  typedef struct packed {
    logic                eb_gt_ea;
    logic [DP_EW-1:0]    e_max;
    logic [DP_SW-1:0]    as;
    logic                sat;
    logic                a_spec;
    logic                b_spec;
  } exp_align_t;

endpackage

// File: rtl/exp_align_pipe_if.sv
// Valid/ready bus of the exponent-align stage: producer drives exponents and
// out_ready (master), the pipeline drives ready and the result (slave).
interface exp_align_pipe_if #(
  parameter int EW = 11,
  parameter int SW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] ea;
  logic [EW-1:0] eb;
  logic          out_valid;
  logic          out_ready;
  logic          eb_gt_ea;
  logic [EW-1:0] e_max;
  logic [SW-1:0] as;
  logic          sat;
  logic          a_spec;
  logic          b_spec;

  modport master (
    output in_valid, ea, eb, out_ready,
    input  in_ready, out_valid, eb_gt_ea, e_max, as, sat, a_spec, b_spec
  );

  modport slave (
    input  in_valid, ea, eb, out_ready,
    output in_ready, out_valid, eb_gt_ea, e_max, as, sat, a_spec, b_spec
  );
endinterface

// File: rtl/exp_align_pipe_exp_diff.sv
// Combinational exponent comparator: EW+1-bit difference gives the ordering,
// both unsigned magnitudes are produced so stage 2 only has to select.
module exp_diff #(
  parameter int EW = 11
) (
  input  logic [EW-1:0] ea,
  input  logic [EW-1:0] eb,
  output logic          eb_gt_ea,
  output logic [EW-1:0] mag_ab,
  output logic [EW-1:0] mag_ba
);
  logic [EW:0] d_s;

  assign d_s      = {1'b0, ea} - {1'b0, eb};
  assign eb_gt_ea = d_s[EW];
  assign mag_ab   = ea - eb;
  assign mag_ba   = eb - ea;
endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent-align pipeline with valid/ready backpressure.
// Optional Inf/NaN exponent override enabled by EXP_ALIGN_SPECIAL_EN.
module exp_align_pipe
  import fpu_add_pkg::*;
#(
  parameter int EW        = DP_EW,
  parameter int MAX_SHIFT = DP_MAX_SHIFT,
  parameter int SW        = $clog2(MAX_SHIFT + 1)
) (
  input logic             clk,
  input logic             rst_n,
  exp_align_pipe_if.slave bus
);
  logic          s1_v_r, s2_v_r;
  logic          s1_load_s, s2_load_s;
  logic          gt_s;
  logic [EW-1:0] mab_s, mba_s;
  logic          asp_s, bsp_s, special_s;
  logic          s1_gt_r, s1_asp_r, s1_bsp_r;
  logic [EW-1:0] s1_ea_r, s1_eb_r, s1_mab_r, s1_mba_r;
  logic [EW-1:0] mag_s, emax_s;
  logic [SW-1:0] as_s;
  logic          sat_s;
  logic          out_gt_r, out_sat_r, out_asp_r, out_bsp_r;
  logic [EW-1:0] out_emax_r;
  logic [SW-1:0] out_as_r;

  exp_diff #(.EW(EW)) u_exp_diff (
    .ea       (bus.ea),
    .eb       (bus.eb),
    .eb_gt_ea (gt_s),
    .mag_ab   (mab_s),
    .mag_ba   (mba_s)
  );

`ifdef EXP_ALIGN_SPECIAL_EN
  assign asp_s     = &bus.ea;
  assign bsp_s     = &bus.eb;
  assign special_s = s1_asp_r | s1_bsp_r;
`else
  assign asp_s     = 1'b0;
  assign bsp_s     = 1'b0;
  assign special_s = 1'b0;
`endif

  // Stage load enables; in_ready is combinational from out_ready.
  always_comb begin
    s2_load_s = !s2_v_r || bus.out_ready;
    s1_load_s = !s1_v_r || s2_load_s;
  end

  assign bus.in_ready = s1_load_s;

  // Stage-2 result: select magnitude and larger exponent, saturate the shift.
  always_comb begin
    mag_s  = s1_gt_r ? s1_mba_r : s1_mab_r;
    emax_s = s1_gt_r ? s1_eb_r : s1_ea_r;
    if (special_s) begin
      sat_s = 1'b0;
      as_s  = {SW{1'b0}};
    end else if (mag_s > EW'(MAX_SHIFT)) begin
      sat_s = 1'b1;
      as_s  = SW'(MAX_SHIFT);
    end else begin
      sat_s = 1'b0;
      as_s  = mag_s[SW-1:0];
    end
  end

  // Stage-1 registers: capture exponents and comparator results on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r   <= 1'b0;
      s1_gt_r  <= 1'b0;
      s1_ea_r  <= {EW{1'b0}};
      s1_eb_r  <= {EW{1'b0}};
      s1_mab_r <= {EW{1'b0}};
      s1_mba_r <= {EW{1'b0}};
      s1_asp_r <= 1'b0;
      s1_bsp_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_v_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_gt_r  <= gt_s;
        s1_ea_r  <= bus.ea;
        s1_eb_r  <= bus.eb;
        s1_mab_r <= mab_s;
        s1_mba_r <= mba_s;
        s1_asp_r <= asp_s;
        s1_bsp_r <= bsp_s;
      end
    end
  end

  // Stage-2 registers: outputs only change when stage 2 reloads with valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_r     <= 1'b0;
      out_gt_r   <= 1'b0;
      out_emax_r <= {EW{1'b0}};
      out_as_r   <= {SW{1'b0}};
      out_sat_r  <= 1'b0;
      out_asp_r  <= 1'b0;
      out_bsp_r  <= 1'b0;
    end else if (s2_load_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        out_gt_r   <= s1_gt_r;
        out_emax_r <= emax_s;
        out_as_r   <= as_s;
        out_sat_r  <= sat_s;
        out_asp_r  <= s1_asp_r;
        out_bsp_r  <= s1_bsp_r;
      end
    end
  end

  assign bus.out_valid = s2_v_r;
  assign bus.eb_gt_ea  = out_gt_r;
  assign bus.e_max     = out_emax_r;
  assign bus.as        = out_as_r;
  assign bus.sat       = out_sat_r;
  assign bus.a_spec    = out_asp_r;
  assign bus.b_spec    = out_bsp_r;
endmodule

// File: tb/tb_exp_align_pipe.sv
// Self-checking bench for exp_align_pipe: directed test-plan steps followed by
// randomized traffic against an arithmetic reference model and result queue.
module tb_exp_align_pipe;
  localparam int EW   = 11;
  localparam int MAXS = 55;
  localparam int EMAX = (1 << EW) - 1;

  typedef struct {
    int gt;
    int emax;
    int as;
    int sat;
    int asp;
    int bsp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;
  exp_t q[$];
  exp_t snap;
  bit   prev_stall = 1'b0;

  exp_align_pipe_if #(.EW(EW), .SW(6)) bus ();

  exp_align_pipe #(.EW(EW), .MAX_SHIFT(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   mag;
    mag    = (a > b) ? (a - b) : (b - a);
    e.gt   = (b > a) ? 1 : 0;
    e.emax = (b > a) ? b : a;
    e.sat  = (mag > MAXS) ? 1 : 0;
    e.as   = (mag > MAXS) ? MAXS : mag;
    e.asp  = 0;
    e.bsp  = 0;
`ifdef EXP_ALIGN_SPECIAL_EN
    e.asp = (a == EMAX) ? 1 : 0;
    e.bsp = (b == EMAX) ? 1 : 0;
    if (e.asp == 1 || e.bsp == 1) begin
      e.as  = 0;
      e.sat = 0;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".eb_gt_ea"}, {31'd0, bus.eb_gt_ea}, e.gt);
    chk({tag, ".e_max"}, {21'd0, bus.e_max}, e.emax);
    chk({tag, ".as"}, {26'd0, bus.as}, e.as);
    chk({tag, ".sat"}, {31'd0, bus.sat}, e.sat);
    chk({tag, ".a_spec"}, {31'd0, bus.a_spec}, e.asp);
    chk({tag, ".b_spec"}, {31'd0, bus.b_spec}, e.bsp);
  endtask

  // One clock cycle: drive, check outputs/stability, track accepts, advance.
  task automatic cycle(input bit v, input int a, input int b, input bit ordy);
    exp_t e;
    bus.in_valid  = v;
    bus.ea        = a[EW-1:0];
    bus.eb        = b[EW-1:0];
    bus.out_ready = ordy;
    #2;
    if (prev_stall) begin
      chk("hold.out_valid", {31'd0, bus.out_valid}, 1);
      chk_out("hold", snap);
    end
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk_out("result", e);
      end
    end
    prev_stall = bus.out_valid && !ordy;
    snap.gt   = bus.eb_gt_ea;
    snap.emax = bus.e_max;
    snap.as   = bus.as;
    snap.sat  = bus.sat;
    snap.asp  = bus.a_spec;
    snap.bsp  = bus.b_spec;
    if (v && bus.in_ready) q.push_back(model(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, 0, 0, 1'b1);
    chk(tag, q.size(), 0);
  endtask

  initial begin
    exp_t z;
    int a, b, mode;
    z = '{0, 0, 0, 0, 0, 0};
    bus.in_valid  = 1'b0;
    bus.ea        = '0;
    bus.eb        = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 0);
    chk_out("rst", z);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", {31'd0, bus.in_ready}, 1);

    // Equal exponents, with explicit 2-cycle latency
    cycle(1'b1, 1, 1, 1'b1);
    chk("lat.edge1", {31'd0, bus.out_valid}, 0);
    cycle(1'b0, 0, 0, 1'b1);
    chk("lat.edge2", {31'd0, bus.out_valid}, 1);
    drain("drain.equal");

    // Test-plan vectors, back to back
    cycle(1'b1, 1030, 1023, 1'b1);
    cycle(1'b1, 682, 1365, 1'b1);
    cycle(1'b1, 1024, 968, 1'b1);
    cycle(1'b1, 1024, 969, 1'b1);
    drain("drain.plan");

    // Stall: two accepts fill the pipe, in_ready drops, outputs hold
    cycle(1'b1, 5, 3, 1'b0);
    cycle(1'b1, 3, 5, 1'b0);
    chk("stall.in_ready", {31'd0, bus.in_ready}, 0);
    cycle(1'b1, 7, 7, 1'b0);
    cycle(1'b1, 7, 7, 1'b0);
    chk("stall.q", q.size(), 2);
    cycle(1'b1, 7, 7, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    drain("drain.stall");

    // All-ones exponent
    cycle(1'b1, EMAX, 1000, 1'b1);
    drain("drain.special");

    // Reset with two results in flight
    cycle(1'b1, 100, 10, 1'b0);
    cycle(1'b1, 20, 200, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 0);
    chk("midrst.e_max", {21'd0, bus.e_max}, 0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b1);
    chk("postrst.out_valid", {31'd0, bus.out_valid}, 0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      a    = $urandom_range(0, EMAX);
      mode = $urandom_range(0, 3);
      case (mode)
        0: b = $urandom_range(0, EMAX);
        1: b = a + $urandom_range(0, 120) - 60;
        2: b = EMAX;
        default: b = a;
      endcase
      if (b < 0) b = 0;
      if (b > EMAX) b = EMAX;
      if ($urandom_range(0, 1) == 1) begin
        mode = a;
        a    = b;
        b    = mode;
      end
      cycle($urandom_range(0, 9) < 7, a, b, $urandom_range(0, 9) < 7);
    end
    drain("drain.random");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
